pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_fwd_select.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// forwarding-mux select codes and the halt opcode.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Forwarding mux select codes (FWD1/FWD2 in EX)
  localparam logic [1:0] FWD_RF  = 2'd0;  // register file operand
  localparam logic [1:0] FWD_MEM = 2'd1;  // ALUResult_MEM (EX-stage producer)
  localparam logic [1:0] FWD_WB  = 2'd2;  // writeback data (MEM-stage producer)
  localparam logic [1:0] FWD_R0  = 2'd3;  // r0 special-write path

  localparam logic [3:0] HALT_OPCODE = 4'hF;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Combinational forwarding-select decode for one ID-stage source operand.
// EX-stage producers take priority over MEM-stage producers.
module fwd_select
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] i_ra_id,
  input  logic [REG_AW-1:0] i_ra1_ex,
  input  logic              i_regwrite_ex,
  input  logic              i_r0write_ex,
  input  logic              i_memread_ex,
  input  logic [REG_AW-1:0] i_ra1_mem,
  input  logic              i_regwrite_mem,
  output logic [1:0]        o_sel
);

  // Priority decode: r0 write, then EX ALU result, then MEM writeback, else RF
  always_comb begin
    o_sel = FWD_RF;
    if (i_r0write_ex && (i_ra_id == '0)) begin
      o_sel = FWD_R0;
    end else if (i_regwrite_ex && !i_memread_ex && (i_ra1_ex == i_ra_id)) begin
      o_sel = FWD_MEM;
    end else if (i_regwrite_mem && (i_ra1_mem == i_ra_id)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall FSM (RUN/STALL/HALTED), IF/ID
// flush on redirect, and registered forwarding selects for EX.
// Optional feature macro: HAZARD_PERF_EN adds a saturating stall counter
// output stall_cnt.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        opcode_ID,
  input  logic [REG_AW-1:0] RA1_ID,
  input  logic [REG_AW-1:0] RA2_ID,
  input  logic [1:0]        PCSource,
  input  logic              Halt,
  input  logic [REG_AW-1:0] RA1_EX,
  input  logic              regWrite_EX,
  input  logic              r0Write_EX,
  input  logic              memRead_EX,
  input  logic [REG_AW-1:0] RA1_MEM,
  input  logic              regWrite_MEM,
  input  logic              r0Write_MEM,
  output logic              Hazard,
  output logic              bubble_IDEX,
  output logic              flush_IFID,
  output logic [1:0]        fwd1_sel_EX,
  output logic [1:0]        fwd2_sel_EX,
  output logic              halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  state_t      r_state;
  state_t      w_state_next;
  logic        w_load_use;
  logic        w_hazard;
  logic        w_bubble;
  logic        w_flush;
  logic [1:0]  w_sel1;
  logic [1:0]  w_sel2;
  logic [1:0]  r_fwd1_sel;
  logic [1:0]  r_fwd2_sel;

  // Halt decode arrives pre-qualified on Halt; the opcode and the MEM r0 flag
  // are not needed by the hazard logic.
  logic w_unused;
  assign w_unused = ^{(opcode_ID == HALT_OPCODE), r0Write_MEM};

  assign w_load_use = memRead_EX && regWrite_EX &&
                      ((RA1_EX == RA1_ID) || (RA1_EX == RA2_ID));

  fwd_select #(.REG_AW(REG_AW)) u_fwd1 (
    .i_ra_id        (RA1_ID),
    .i_ra1_ex       (RA1_EX),
    .i_regwrite_ex  (regWrite_EX),
    .i_r0write_ex   (r0Write_EX),
    .i_memread_ex   (memRead_EX),
    .i_ra1_mem      (RA1_MEM),
    .i_regwrite_mem (regWrite_MEM),
    .o_sel          (w_sel1)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd2 (
    .i_ra_id        (RA2_ID),
    .i_ra1_ex       (RA1_EX),
    .i_regwrite_ex  (regWrite_EX),
    .i_r0write_ex   (r0Write_EX),
    .i_memread_ex   (memRead_EX),
    .i_ra1_mem      (RA1_MEM),
    .i_regwrite_mem (regWrite_MEM),
    .o_sel          (w_sel2)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and combinational hazard outputs; a stall beats a coincident
  // halt or redirect, which are re-evaluated on the following cycle.
  always_comb begin
    w_state_next = r_state;
    w_hazard     = 1'b0;
    w_bubble     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_load_use) begin
          w_hazard     = 1'b1;
          w_bubble     = 1'b1;
          w_state_next = ST_STALL;
        end else if (Halt) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_STALL:  w_state_next = Halt ? ST_HALTED : ST_RUN;
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_RUN;
    endcase
    if (!reset) begin
      w_hazard = 1'b0;
      w_bubble = 1'b0;
    end
    w_flush = reset && (PCSource != 2'b00) && !w_hazard && (r_state != ST_HALTED);
  end

  // Forwarding selects follow the instruction into EX; a bubble enters EX as
  // a NOP so it gets RF selects, and a halted pipe keeps them cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fwd1_sel <= FWD_RF;
      r_fwd2_sel <= FWD_RF;
    end else if (w_bubble || (r_state == ST_HALTED)) begin
      r_fwd1_sel <= FWD_RF;
      r_fwd2_sel <= FWD_RF;
    end else if (!w_hazard) begin
      r_fwd1_sel <= w_sel1;
      r_fwd2_sel <= w_sel2;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles with Hazard asserted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

  assign Hazard      = w_hazard;
  assign bubble_IDEX = w_bubble;
  assign flush_IFID  = w_flush;
  assign fwd1_sel_EX = r_fwd1_sel;
  assign fwd2_sel_EX = r_fwd2_sel;
  assign halted      = (r_state == ST_HALTED);

endmodule
